uart_echo_fifo: RTL and testbench

Buffered, parametrised echo engine that sits between the osdvu `uart` core's byte interface and nothing else: every correctly received byte is queued in a FIFO and retransmitted in order. It replaces the unbuffered single-register echo loop and survives back-to-back receive bursts while the transmitter is busy. It adds sticky overflow reporting, a transmit-start timeout and optional statistics counters.

---
 rtl/uart_echo_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffered echo engine for the osdvu uart byte interface.
// Every cleanly received byte is queued in a circular FIFO and handed back
// to the transmitter in arrival order. A small FSM issues tx_start and waits
// for the core to acknowledge with tx_busy, giving up after BUSY_TIMEOUT
// cycles.
//
// Optional feature macro: UART_ECHO_STATS_EN
//   defined     -> drop_count / err_count are saturating counters
//   not defined -> drop_count / err_count are tied to zero
module uart_echo_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int CNT_W        = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_received,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_error,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_count,
  output logic [CNT_W-1:0]      err_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Timeout counter only needs to reach BUSY_TIMEOUT-1.
  localparam int TW    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [TW-1:0]       TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  empty_q, full_q;
  logic                  ovf_q;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  start_q, start_d;
  logic [7:0]            byte_q, byte_d;

  logic                  rx_ok;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  timeout;

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  // A pop happens only from IDLE with data queued and the core free. When
  // full, a pop in the same cycle frees the slot the incoming byte needs.
  assign rx_ok   = rx_received && !rx_error;
  assign pop     = (state_q == IDLE) && !empty_q && !tx_busy;
  assign push    = rx_ok && (!full_q || pop);
  assign drop    = rx_ok && full_q && !pop;
  assign timeout = (state_q == WAIT_BUSY) && !tx_busy && (tmo_q == TMO_LAST);

  // Occupancy next-state: push and pop together leave the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Byte storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q] <= rx_byte;
    end
  end

  // Pointers, occupancy, registered status flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == FULL_LVL);
      if (drop) ovf_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  // FSM state and registered transmit outputs. Reset does not look at
  // tx_busy: IDLE already refuses to start while the core is still busy,
  // so a frame in flight across reset finishes undisturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      start_q <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state logic: tx_byte is loaded only on a pop and otherwise held.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    start_d = start_q;
    byte_d  = byte_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          byte_d  = mem_q[rptr_q];
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (timeout) begin
          // Core never picked the byte up; it is abandoned.
          start_d = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
`ifdef UART_ECHO_STATS_EN
  logic [CNT_W-1:0] drop_q, err_q;
  logic [1:0]       err_inc;
  logic [CNT_W:0]   err_sum;

  // A receive error and a timeout can coincide, so errors may add 2.
  assign err_inc = {1'b0, rx_received && rx_error} + {1'b0, timeout};
  assign err_sum = {1'b0, err_q} + {{(CNT_W-1){1'b0}}, err_inc};

  // Saturating drop and error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      if (drop && !(&drop_q)) drop_q <= drop_q + 1'b1;
      err_q <= err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end
  end

  assign drop_count = drop_q;
  assign err_count  = err_q;
`else
  assign drop_count = '0;
  assign err_count  = '0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign tx_start   = start_q;
  assign tx_byte    = byte_q;
  assign fifo_level = level_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo (DEPTH_LOG2=2, BUSY_TIMEOUT=64).
// A queue-based model predicts every output each cycle; directed scenarios
// add literal expectations that pin the model.
module tb_uart_echo_fifo;
  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int BT    = 64;
  localparam int CMAX  = 65535;
`ifdef UART_ECHO_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, rx_received, rx_error, tx_busy;
  logic [7:0]    rx_byte;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic [DL:0]   fifo_level;
  logic          fifo_empty, fifo_full, overflow;
  logic [CW-1:0] drop_count, err_count;

  uart_echo_fifo #(.DEPTH_LOG2(DL), .CNT_W(CW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .rx_received(rx_received), .rx_byte(rx_byte),
    .rx_error(rx_error), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_byte(tx_byte), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overflow(overflow), .drop_count(drop_count),
    .err_count(err_count));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  bit         m_start;
  logic [7:0] m_byte;
  int         m_phase;   // 0 idle, 1 awaiting busy, 2 awaiting done
  int         m_wait;
  bit         m_ovf;
  int         m_drop, m_err;
  bit         chk_en = 0;

  initial begin
    bit s_rst, s_rx, s_err, s_busy;
    logic [7:0] s_b;
    int einc;
    forever begin
      @(posedge clk);
      s_rst = rst; s_rx = rx_received; s_err = rx_error; s_busy = tx_busy; s_b = rx_byte;
      if (s_rst) begin
        m_q.delete(); m_start = 0; m_byte = 8'h00; m_phase = 0; m_wait = 0;
        m_ovf = 0; m_drop = 0; m_err = 0; chk_en = 1;
      end else begin
        einc = (s_rx && s_err) ? 1 : 0;
        if (m_phase == 0 && m_q.size() > 0 && !s_busy) begin
          m_byte = m_q.pop_front(); m_start = 1; m_phase = 1; m_wait = 0;
        end else if (m_phase == 1) begin
          if (s_busy) begin m_start = 0; m_phase = 2; end
          else begin
            m_wait++;
            if (m_wait == BT) begin m_start = 0; m_phase = 0; einc++; end
          end
        end else if (m_phase == 2 && !s_busy) m_phase = 0;
        // Byte queued after the head left, so a same-cycle pop makes room.
        if (s_rx && !s_err) begin
          if (m_q.size() < DEPTH) m_q.push_back(s_b);
          else begin m_ovf = 1; if (m_drop < CMAX) m_drop++; end
        end
        m_err = (m_err + einc > CMAX) ? CMAX : m_err + einc;
      end
      #1;
      if (chk_en) begin
        chk("m_tx_start", 32'(tx_start), 32'(m_start));
        chk("m_tx_byte", 32'(tx_byte), 32'(m_byte));
        chk("m_level", 32'(fifo_level), 32'(m_q.size()));
        chk("m_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
        chk("m_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_drop", 32'(drop_count), 32'(STATS ? m_drop : 0));
        chk("m_err", 32'(err_count), 32'(STATS ? m_err : 0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx(input logic [7:0] b, input bit e);
    rx_received = 1'b1; rx_byte = b; rx_error = e;
    @(negedge clk);
    rx_received = 1'b0; rx_error = 1'b0;
  endtask

  // Waits (bounded) for tx_start, then plays the uart core for one frame.
  task automatic echo_one(output logic [7:0] b);
    int n = 0;
    while (!tx_start && n < 200) begin n++; @(negedge clk); end
    chk("echo_wait_start", 32'(tx_start), 32'd1);
    b = tx_byte;
    tx_busy = 1'b1;
    tick(4);
    tx_busy = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [7:0] b;
    int d0, e0, e1, n;
    rst = 1; rx_received = 0; rx_error = 0; rx_byte = 8'h00; tx_busy = 0;
    tick(2);
    rst = 0;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);

    // Single echo: level 0->1->0, tx_start two edges after the strobe.
    rx(8'h41, 0);
    chk("echo_level1", 32'(fifo_level), 32'd1);
    chk("echo_start_early", 32'(tx_start), 32'd0);
    tick(1);
    chk("echo_start", 32'(tx_start), 32'd1);
    chk("echo_byte", 32'(tx_byte), 32'h41);
    chk("echo_level0", 32'(fifo_level), 32'd0);
    tick(3);
    chk("echo_start_hold", 32'(tx_start), 32'd1);
    tx_busy = 1; tick(1);
    chk("echo_start_drop", 32'(tx_start), 32'd0);
    tick(3); tx_busy = 0; tick(2);

    // Burst of 6 into depth 4 while the core is busy.
    tx_busy = 1; tick(1);
    for (int i = 1; i <= 6; i++) rx(8'(i), 0);
    chk("burst_level", 32'(fifo_level), 32'd4);
    chk("burst_full", 32'(fifo_full), 32'd1);
    chk("burst_ovf", 32'(overflow), 32'd1);
    chk("burst_drop", 32'(drop_count), 32'(STATS * 2));
    tx_busy = 0;
    for (int i = 1; i <= 4; i++) begin
      echo_one(b);
      chk("burst_order", 32'(b), 32'(i));
    end
    tick(2);
    chk("burst_drained", 32'(fifo_empty), 32'd1);

    // Push at full in the same cycle the head is popped.
    tx_busy = 1; tick(1);
    for (int i = 1; i <= 4; i++) rx(8'hA0 + 8'(i), 0);
    chk("pf_full", 32'(fifo_full), 32'd1);
    d0 = int'(drop_count);
    tx_busy = 0;
    rx(8'hA5, 0);
    chk("pf_level", 32'(fifo_level), 32'd4);
    chk("pf_nodrop", 32'(drop_count), 32'(d0));
    chk("pf_start", 32'(tx_start), 32'd1);
    chk("pf_byte", 32'(tx_byte), 32'hA1);
    tx_busy = 1; tick(3); tx_busy = 0;
    for (int i = 2; i <= 5; i++) begin
      echo_one(b);
      chk("pf_order", 32'(b), 32'hA0 + 32'(i));
    end
    tick(2);

    // Receive error: discarded and counted.
    e0 = int'(err_count);
    rx(8'h55, 1);
    chk("rxerr_level", 32'(fifo_level), 32'd0);
    chk("rxerr_count", 32'(err_count), 32'(e0 + STATS));
    chk("rxerr_nostart", 32'(tx_start), 32'd0);
    tick(2);

    // Timeout: tx_busy never rises.
    e1 = int'(err_count);
    rx(8'h77, 0);
    rx(8'h78, 0);
    n = 0;
    while (tx_start && n < 200) begin n++; tick(1); end
    chk("tmo_high_cycles", 32'(n), 32'd64);
    chk("tmo_err1", 32'(err_count), 32'(e1 + STATS));
    tick(1);
    chk("tmo_next_start", 32'(tx_start), 32'd1);
    chk("tmo_next_byte", 32'(tx_byte), 32'h78);
    // Land a receive error on the very edge of the second timeout.
    tick(63);
    rx(8'h99, 1);
    chk("tmo_dual_err", 32'(err_count), 32'(e1 + 3 * STATS));
    chk("tmo_dual_start", 32'(tx_start), 32'd0);
    tick(2);

    // Reset during WAIT_DONE with three bytes queued.
    rx(8'hC1, 0);
    tick(1);
    chk("rstw_start", 32'(tx_start), 32'd1);
    tx_busy = 1; tick(1);
    rx(8'hC2, 0); rx(8'hC3, 0); rx(8'hC4, 0);
    chk("rstw_level", 32'(fifo_level), 32'd3);
    rst = 1; tick(1); rst = 0;
    chk("rstw_level0", 32'(fifo_level), 32'd0);
    chk("rstw_empty", 32'(fifo_empty), 32'd1);
    chk("rstw_full", 32'(fifo_full), 32'd0);
    chk("rstw_tx_start", 32'(tx_start), 32'd0);
    chk("rstw_tx_byte", 32'(tx_byte), 32'h00);
    chk("rstw_ovf", 32'(overflow), 32'd0);
    chk("rstw_drop", 32'(drop_count), 32'd0);
    chk("rstw_err", 32'(err_count), 32'd0);
    tick(3);
    chk("rstw_busy_hold", 32'(tx_start), 32'd0);
    tx_busy = 0; tick(3);
    chk("rstw_idle_quiet", 32'(tx_start), 32'd0);
    rx(8'hD1, 0);
    tick(1);
    chk("rstw_restart", 32'(tx_start), 32'd1);
    chk("rstw_restart_byte", 32'(tx_byte), 32'hD1);
    tx_busy = 1; tick(2); tx_busy = 0; tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
